fill_rect_cmd_encoder: RTL and testbench

Serializes a parallel fill-rectangle command into the 11-byte stream carried on the 8-bit command FIFO. The stream is consumed by the fill-rect decode engine. Sits between the host/command-generation logic and the command FIFO write port. Holds one pending command while another is serialized, so the host can queue the next rectangle without waiting for the byte stream to drain.

---
 rtl/fill_rect_cmd_encoder_if.sv | 28 ++
 rtl/fill_rect_cmd_encoder.sv | 131 +++++++++++++
 tb/tb_fill_rect_cmd_encoder.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fill_rect_cmd_encoder_if.sv
// Handshake and byte-stream signals between host, fill-rect command encoder and command FIFO.
// slave = encoder view, master = host/FIFO side view.
interface fill_rect_cmd_encoder_if;
    logic        host_rts;
    logic        host_rtr;
    logic [15:0] host_origx;
    logic [15:0] host_origy;
    logic [15:0] host_wid;
    logic [15:0] host_hgt;
    logic [3:0]  host_rval;
    logic [3:0]  host_gval;
    logic [3:0]  host_bval;
    logic        enc_rts;
    logic        enc_rtr;
    logic [7:0]  enc_data;

    modport slave (
        input  host_rts, host_origx, host_origy, host_wid, host_hgt,
        input  host_rval, host_gval, host_bval, enc_rtr,
        output host_rtr, enc_rts, enc_data
    );

    modport master (
        output host_rts, host_origx, host_origy, host_wid, host_hgt,
        output host_rval, host_gval, host_bval, enc_rtr,
        input  host_rtr, enc_rts, enc_data
    );
endinterface

// File: rtl/fill_rect_cmd_encoder.sv
// Serializes one fill-rect command into 11 big-endian bytes, with a one-deep holding register.
// Optional macro FILL_RECT_ENC_DROP_EMPTY_EN discards commands with zero width or height.
module fill_rect_cmd_encoder #(
    parameter int CMD_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_,
    fill_rect_cmd_encoder_if.slave bus,
    output logic                 enc_busy,
    output logic [CMD_CNT_W-1:0] cmd_count
);
    localparam logic [3:0] LAST_IDX = 4'd10;

    typedef enum logic {ST_IDLE, ST_SEND} state_t;

    // Command layout: {origx, origy, wid, hgt, r, g, b}
    state_t                r_state;
    state_t                w_state_next;
    logic [75:0]           r_hold;
    logic [75:0]           r_active;
    logic                  r_hold_valid;
    logic                  w_hold_valid_next;
    logic [3:0]            r_idx;
    logic [3:0]            w_idx_next;
    logic [CMD_CNT_W-1:0]  r_cmd_count;
    logic                  w_host_xfc;
    logic                  w_load;
    logic                  w_count_inc;
    logic                  w_drop;
    logic [63:0]           w_geom;
    logic [7:0]            w_bytes [0:10];

    assign bus.host_rtr = ~r_hold_valid;
    assign w_host_xfc   = bus.host_rts & ~r_hold_valid;
    assign bus.enc_rts  = (r_state == ST_SEND);
    assign enc_busy     = (r_state == ST_SEND);
    assign cmd_count    = r_cmd_count;

`ifdef FILL_RECT_ENC_DROP_EMPTY_EN
    assign w_drop = (r_hold[43:28] == 16'h0000) || (r_hold[27:12] == 16'h0000);
`else
    assign w_drop = 1'b0;
`endif

    // A pending command is consumed whenever the active slot frees up: in IDLE,
    // or on the final byte transfer so the next stream follows with no bubble.
    always_comb begin
        w_state_next      = r_state;
        w_hold_valid_next = r_hold_valid;
        w_idx_next        = r_idx;
        w_load            = 1'b0;
        w_count_inc       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_hold_valid) begin
                    w_hold_valid_next = 1'b0;
                    if (!w_drop) begin
                        w_load       = 1'b1;
                        w_idx_next   = 4'd0;
                        w_state_next = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                if (bus.enc_rtr) begin
                    if (r_idx == LAST_IDX) begin
                        w_count_inc  = 1'b1;
                        w_state_next = ST_IDLE;
                        if (r_hold_valid) begin
                            w_hold_valid_next = 1'b0;
                            if (!w_drop) begin
                                w_load       = 1'b1;
                                w_idx_next   = 4'd0;
                                w_state_next = ST_SEND;
                            end
                        end
                    end else begin
                        w_idx_next = r_idx + 4'd1;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
        if (w_host_xfc) begin
            w_hold_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state      <= ST_IDLE;
            r_hold_valid <= 1'b0;
            r_hold       <= '0;
            r_active     <= '0;
            r_idx        <= 4'd0;
            r_cmd_count  <= '0;
        end else begin
            r_state      <= w_state_next;
            r_hold_valid <= w_hold_valid_next;
            r_idx        <= w_idx_next;
            if (w_host_xfc) begin
                r_hold <= {bus.host_origx, bus.host_origy, bus.host_wid, bus.host_hgt,
                           bus.host_rval, bus.host_gval, bus.host_bval};
            end
            if (w_load) begin
                r_active <= r_hold;
            end
            if (w_count_inc) begin
                r_cmd_count <= r_cmd_count + 1'b1;
            end
        end
    end

    assign w_geom = r_active[75:12];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_geom_bytes
            assign w_bytes[gi] = w_geom[63-8*gi -: 8];
        end
        for (genvar gi = 0; gi < 3; gi++) begin : g_colour_bytes
            assign w_bytes[8+gi] = {4'h0, r_active[11-4*gi -: 4]};
        end
    endgenerate

    always_comb begin
        bus.enc_data = 8'h00;
        if (r_idx <= LAST_IDX) begin
            bus.enc_data = w_bytes[r_idx];
        end
    end
endmodule

// File: tb/tb_fill_rect_cmd_encoder.sv
// Scoreboard bench for fill_rect_cmd_encoder: a driver pushes the expected byte stream per command,
// an independent monitor pops and compares every accepted byte and tracks the expected command count.
module tb_fill_rect_cmd_encoder;
    localparam int CNT_W = 2;

    logic clk = 1'b0;
    logic rst_ = 1'b0;
    always #5 clk = ~clk;

    fill_rect_cmd_encoder_if bus ();
    logic             enc_busy;
    logic [CNT_W-1:0] cmd_count;

    fill_rect_cmd_encoder #(.CMD_CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_      (rst_),
        .bus       (bus),
        .enc_busy  (enc_busy),
        .cmd_count (cmd_count)
    );

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q [$];
    int         exp_count = 0;
    int         byte_in_cmd = 0;
    int         cmds_done = 0;
    logic       rtr_random = 1'b0;
    logic       rtr_force = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a command becomes its 11 big-endian bytes, unless it is dropped.
    function automatic void model_push(input logic [15:0] ox, oy, w, h, input logic [3:0] r, g, b);
`ifdef FILL_RECT_ENC_DROP_EMPTY_EN
        if (w == 16'd0 || h == 16'd0) return;
`endif
        exp_q.push_back(8'(ox >> 8)); exp_q.push_back(8'(ox));
        exp_q.push_back(8'(oy >> 8)); exp_q.push_back(8'(oy));
        exp_q.push_back(8'(w >> 8));  exp_q.push_back(8'(w));
        exp_q.push_back(8'(h >> 8));  exp_q.push_back(8'(h));
        exp_q.push_back({4'h0, r});   exp_q.push_back({4'h0, g}); exp_q.push_back({4'h0, b});
    endfunction

    task automatic send_cmd(input logic [15:0] ox, oy, w, h, input logic [3:0] r, g, b);
        int n = 0;
        @(negedge clk);
        while (!bus.host_rtr && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("host_rtr_wait", 32'(n < 500), 32'd1);
        bus.host_origx = ox; bus.host_origy = oy; bus.host_wid = w; bus.host_hgt = h;
        bus.host_rval = r;   bus.host_gval = g;   bus.host_bval = b;
        bus.host_rts = 1'b1;
        @(posedge clk);
        #1;
        bus.host_rts = 1'b0;
        model_push(ox, oy, w, h, r, g, b);
    endtask

    task automatic wait_drain();
        int n;
        for (n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.enc_rts) break;
        end
        chk("drain_in_budget", 32'(n < 3000), 32'd1);
    endtask

    // FIFO-side ready: random or forced, updated mid-cycle so negedge samples match the next edge.
    initial begin
        bus.enc_rtr = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            bus.enc_rtr = rtr_random ? ($urandom_range(0, 3) != 0) : rtr_force;
        end
    end

    // Monitor: compare accepted bytes against the scoreboard and track cmd_count.
    initial begin
        logic       prev_stall;
        logic [7:0] prev_data;
        logic [7:0] e;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_) begin
                prev_stall = 1'b0;
            end else begin
                chk("cmd_count", 32'(cmd_count), 32'(exp_count));
                chk("enc_busy", 32'(enc_busy), 32'(bus.enc_rts));
                if (prev_stall) begin
                    chk("stall_rts", 32'(bus.enc_rts), 32'd1);
                    chk("stall_data", 32'(bus.enc_data), 32'(prev_data));
                end
                if (bus.enc_rts && bus.enc_rtr) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_byte", 32'(bus.enc_data), 32'h100);
                    end else begin
                        e = exp_q.pop_front();
                        chk("stream_byte", 32'(bus.enc_data), 32'(e));
                        byte_in_cmd++;
                        if (byte_in_cmd == 11) begin
                            byte_in_cmd = 0;
                            exp_count = (exp_count + 1) % (1 << CNT_W);
                            cmds_done++;
                            $display("cmd %0d sent, expected cmd_count=%0d", cmds_done, exp_count);
                        end
                    end
                end
                prev_stall = bus.enc_rts && !bus.enc_rtr;
                prev_data  = bus.enc_data;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int drops;
        int rtr_bad;
        logic [15:0] ox, oy, w, h;

        bus.host_rts = 1'b0;
        bus.host_origx = '0; bus.host_origy = '0; bus.host_wid = '0; bus.host_hgt = '0;
        bus.host_rval = '0;  bus.host_gval = '0;  bus.host_bval = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_host_rtr", 32'(bus.host_rtr), 32'd1);
        chk("rst_enc_rts", 32'(bus.enc_rts), 32'd0);
        chk("rst_enc_data", 32'(bus.enc_data), 32'h00);
        chk("rst_enc_busy", 32'(enc_busy), 32'd0);
        chk("rst_cmd_count", 32'(cmd_count), 32'd0);
        rst_ = 1'b1;

        // Single command, two-cycle latency to first byte.
        rtr_force = 1'b1;
        send_cmd(16'h0102, 16'h0304, 16'h0010, 16'h0020, 4'hA, 4'h5, 4'hF);
        @(negedge clk);
        chk("latency_no_byte_yet", 32'(bus.enc_rts), 32'd0);
        @(negedge clk);
        chk("latency_first_rts", 32'(bus.enc_rts), 32'd1);
        chk("latency_first_byte", 32'(bus.enc_data), 32'h01);
        wait_drain();

        // Backpressure while byte 3 is presented.
        send_cmd(16'h0102, 16'h0304, 16'h0010, 16'h0020, 4'hA, 4'h5, 4'hF);
        repeat (4) @(posedge clk);
        #1;
        rtr_force = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_data", 32'(bus.enc_data), 32'h04);
        end
        @(posedge clk);
        #1;
        rtr_force = 1'b1;
        wait_drain();

        // Reset in the middle of a command.
        send_cmd(16'hBEEF, 16'h1234, 16'h0005, 16'h0006, 4'h1, 4'h2, 4'h3);
        repeat (6) @(posedge clk);
        #1;
        rst_ = 1'b0;
        #1;
        chk("midrst_enc_rts", 32'(bus.enc_rts), 32'd0);
        chk("midrst_host_rtr", 32'(bus.host_rtr), 32'd1);
        chk("midrst_cmd_count", 32'(cmd_count), 32'd0);
        chk("midrst_enc_busy", 32'(enc_busy), 32'd0);
        exp_q.delete();
        byte_in_cmd = 0;
        exp_count = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_ = 1'b1;
        send_cmd(16'h0A0B, 16'h0C0D, 16'h0001, 16'h0002, 4'h7, 4'h8, 4'h9);
        wait_drain();

        // Back-to-back: second command queued while the first streams.
        send_cmd(16'($urandom), 16'($urandom), 16'($urandom) | 16'h1, 16'($urandom) | 16'h1, 4'h1, 4'h2, 4'h3);
        send_cmd(16'($urandom), 16'($urandom), 16'($urandom) | 16'h1, 16'($urandom) | 16'h1, 4'h4, 4'h5, 4'h6);
        drops = 0;
        rtr_bad = 0;
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            if (!bus.enc_rts) drops++;
            if (bus.host_rtr !== (i >= 10)) rtr_bad++;
        end
        chk("b2b_no_bubble", 32'(drops), 32'd0);
        chk("b2b_host_rtr_timing", 32'(rtr_bad), 32'd0);
        @(negedge clk);
        chk("b2b_stream_end", 32'(bus.enc_rts), 32'd0);
        wait_drain();

        // Zero-width command.
        send_cmd(16'h0011, 16'h0022, 16'h0000, 16'h0008, 4'h3, 4'h3, 4'h3);
        @(negedge clk);
        chk("empty_hold_busy", 32'(bus.host_rtr), 32'd0);
        @(negedge clk);
`ifdef FILL_RECT_ENC_DROP_EMPTY_EN
        chk("empty_dropped_rts", 32'(bus.enc_rts), 32'd0);
        chk("empty_host_rtr_back", 32'(bus.host_rtr), 32'd1);
`else
        chk("empty_sent_rts", 32'(bus.enc_rts), 32'd1);
`endif
        repeat (15) @(negedge clk);
        wait_drain();

        // Randomized commands with random FIFO backpressure.
        rtr_random = 1'b1;
        for (int k = 0; k < 40; k++) begin
            ox = 16'($urandom);
            oy = 16'($urandom);
            w  = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
            h  = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
            send_cmd(ox, oy, w, h, 4'($urandom), 4'($urandom), 4'($urandom));
            repeat ($urandom_range(0, 12)) @(posedge clk);
        end
        wait_drain();
        rtr_random = 1'b0;
        repeat (3) @(negedge clk);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
